pwm_timer_lbus: RTL and testbench

//  Multi-channel PWM generator as a low-speed-bus (XT_LB) slave, next to LED/GPIO/LEDSD.

---
 rtl/pwm_pkg.sv | 30 +++
 rtl/pwm_channel.sv | 47 ++++
 rtl/pwm_timer_lbus.sv | 153 +++++++++++++++
 tb/tb_pwm_timer_lbus.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM timer: register word indices and the CTRL layout.
package pwm_pkg;

  // Register word indices (addr[4:2])
  localparam logic [2:0] IdxCtrl   = 3'd0;
  localparam logic [2:0] IdxPsc    = 3'd1;
  localparam logic [2:0] IdxPeriod = 3'd2;
  localparam logic [2:0] IdxStatus = 3'd3;
  localparam logic [2:0] IdxDuty0  = 3'd4;

  // CTRL fields; channel-indexed fields are sized for the maximum of four channels
  typedef struct packed {
    logic [3:0] pol;
    logic       irq_en;
    logic       run;
    logic [3:0] ch_en;
  } pwm_ctrl_t;

  // CTRL register image as seen on the bus
  function automatic logic [31:0] ctrl_to_word(input pwm_ctrl_t c);
    logic [31:0] w;
    w        = '0;
    w[3:0]   = c.ch_en;
    w[8]     = c.run;
    w[9]     = c.irq_en;
    w[19:16] = c.pol;
    return w;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty, compare against the shared counter,
// polarity and the registered output.
module pwm_channel #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_sync,
  input  logic             i_duty_we,
  input  logic [CNT_W-1:0] i_wdata,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_run,
  input  logic             i_en,
  input  logic             i_pol,
  output logic [CNT_W-1:0] o_duty_stg,
  output logic             o_pwm
);

  logic [CNT_W-1:0] r_duty_stg;
  logic [CNT_W-1:0] r_duty_act;
  logic             r_pwm;
  logic             w_raw;

  // duty=0 never matches; duty>PERIOD always matches since cnt never exceeds PERIOD
  assign w_raw = i_run & i_en & (i_cnt < r_duty_act);

  // Staging write and shadow load; the shadow takes the pre-write staging value
  always_ff @(posedge i_clk) begin
    if (i_rst_sync) begin
      r_duty_stg <= '0;
      r_duty_act <= '0;
    end else begin
      if (i_duty_we) r_duty_stg <= i_wdata;
      if (i_load)    r_duty_act <= r_duty_stg;
    end
  end

  // Registered output with polarity applied; disabled channels rest at pol
  always_ff @(posedge i_clk) begin
    if (i_rst_sync) r_pwm <= 1'b0;
    else            r_pwm <= w_raw ^ i_pol;
  end

  assign o_duty_stg = r_duty_stg;
  assign o_pwm      = r_pwm;

endmodule

// File: rtl/pwm_timer_lbus.sv
// Multi-channel PWM timer on the low-speed bus: register decode, read mux,
// shared prescaler/period counter, period shadow and wrap interrupt.
module pwm_timer_lbus
  import pwm_pkg::*;
#(
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned PSC_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_sync,
  input  logic              i_sel,
  input  logic              i_we,
  input  logic [4:0]        i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic [CH_NUM-1:0] o_pwm_out,
  output logic              o_irq
);

  localparam int unsigned ChMaskI = (1 << CH_NUM) - 1;
  localparam logic [3:0]  ChMask  = ChMaskI[3:0];

  logic [2:0]                   w_idx;
  logic                         w_wr;
  logic                         w_rd;
  logic                         w_tick;
  logic                         w_wrap;
  logic                         w_load;
  logic [31:0]                  w_rdata_nxt;
  logic [CH_NUM-1:0][CNT_W-1:0] w_duty_stg;
  logic                         w_unused_bus;

  pwm_ctrl_t        r_ctrl;
  logic [PSC_W-1:0] r_psc;
  logic [PSC_W-1:0] r_psc_cnt;
  logic [CNT_W-1:0] r_per_stg;
  logic [CNT_W-1:0] r_per_act;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flag;
  logic             r_irq;
  logic [31:0]      r_rdata;

  assign w_idx        = i_addr[4:2];
  assign w_wr         = i_sel & i_we;
  assign w_rd         = i_sel & ~i_we;
  assign w_unused_bus = ^{i_addr[1:0], i_wdata};

  // psc_cnt above a freshly lowered PSC simply rolls over before the next tick
  assign w_tick = r_ctrl.run & (r_psc_cnt == r_psc);
  assign w_wrap = w_tick & (r_cnt == r_per_act);
  // Shadows follow staging on every wrap and continuously while stopped
  assign w_load = w_wrap | ~r_ctrl.run;

  // Bus-writable configuration registers
  always_ff @(posedge i_clk) begin
    if (i_rst_sync) begin
      r_ctrl    <= '0;
      r_psc     <= '0;
      r_per_stg <= '0;
    end else if (w_wr) begin
      case (w_idx)
        IdxCtrl: begin
          r_ctrl.ch_en  <= i_wdata[3:0] & ChMask;
          r_ctrl.run    <= i_wdata[8];
          r_ctrl.irq_en <= i_wdata[9];
          r_ctrl.pol    <= i_wdata[19:16] & ChMask;
        end
        IdxPsc:    r_psc     <= i_wdata[PSC_W-1:0];
        IdxPeriod: r_per_stg <= i_wdata[CNT_W-1:0];
        default:   ;
      endcase
    end
  end

  // Prescaler and period counter; both held at zero while stopped
  always_ff @(posedge i_clk) begin
    if (i_rst_sync || !r_ctrl.run) begin
      r_psc_cnt <= '0;
      r_cnt     <= '0;
    end else if (w_tick) begin
      r_psc_cnt <= '0;
      r_cnt     <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end else begin
      r_psc_cnt <= r_psc_cnt + PSC_W'(1);
    end
  end

  // Active period shadow
  always_ff @(posedge i_clk) begin
    if (i_rst_sync)  r_per_act <= '0;
    else if (w_load) r_per_act <= r_per_stg;
  end

  // Wrap flag (a wrap beats a same-cycle W1C) and registered level irq
  always_ff @(posedge i_clk) begin
    if (i_rst_sync) begin
      r_flag <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_flag <= 1'b1;
      end else if (w_wr && (w_idx == IdxStatus) && i_wdata[0]) begin
        r_flag <= 1'b0;
      end
      r_irq <= r_flag & r_ctrl.irq_en;
    end
  end

  // Read mux; duty indices beyond the channel count read zero
  always_comb begin
    w_rdata_nxt = '0;
    case (w_idx)
      IdxCtrl:   w_rdata_nxt = ctrl_to_word(r_ctrl);
      IdxPsc:    w_rdata_nxt[PSC_W-1:0] = r_psc;
      IdxPeriod: w_rdata_nxt[CNT_W-1:0] = r_per_stg;
      IdxStatus: w_rdata_nxt[0] = r_flag;
      default: begin
        for (int n = 0; n < CH_NUM; n++) begin
          if (w_idx == IdxDuty0 + 3'(n)) w_rdata_nxt[CNT_W-1:0] = w_duty_stg[n];
        end
      end
    endcase
  end

  // Read data register; holds until the next read
  always_ff @(posedge i_clk) begin
    if (i_rst_sync) r_rdata <= '0;
    else if (w_rd)  r_rdata <= w_rdata_nxt;
  end

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    pwm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst_sync (i_rst_sync),
      .i_duty_we  (w_wr && (w_idx == IdxDuty0 + 3'(n))),
      .i_wdata    (i_wdata[CNT_W-1:0]),
      .i_load     (w_load),
      .i_cnt      (r_cnt),
      .i_run      (r_ctrl.run),
      .i_en       (r_ctrl.ch_en[n]),
      .i_pol      (r_ctrl.pol[n]),
      .o_duty_stg (w_duty_stg[n]),
      .o_pwm      (o_pwm_out[n])
    );
  end

  assign o_rdata = r_rdata;
  assign o_irq   = r_irq;

endmodule

// File: tb/tb_pwm_timer_lbus.sv
// Self-checking bench for pwm_timer_lbus: directed scenarios plus random bus
// traffic compared every cycle against a behavioural model.
module tb_pwm_timer_lbus;

  localparam int unsigned CH_NUM = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PSC_W  = 16;
  localparam int          PscMod = 1 << PSC_W;
  localparam int          ChMask = (1 << CH_NUM) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sel = 1'b0;
  logic              we  = 1'b0;
  logic [4:0]        addr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic [CH_NUM-1:0] pwm;
  logic              irq;

  pwm_timer_lbus #(
    .CH_NUM(CH_NUM),
    .CNT_W (CNT_W),
    .PSC_W (PSC_W)
  ) dut (
    .i_clk      (clk),
    .i_rst_sync (rst),
    .i_sel      (sel),
    .i_we       (we),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_rdata    (rdata),
    .o_pwm_out  (pwm),
    .o_irq      (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Behavioural model state
  int                m_ch_en, m_run, m_irq_en, m_pol, m_psc, m_per_stg, m_per_act;
  int                m_psc_cnt, m_cnt, m_flag, m_irq;
  int                m_duty_stg[CH_NUM];
  int                m_duty_act[CH_NUM];
  logic [31:0]       m_rdata;
  logic [CH_NUM-1:0] m_pwm;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_reg(input int idx);
    logic [31:0] v;
    v = '0;
    case (idx)
      0: v = 32'(m_ch_en) | (32'(m_run) << 8) | (32'(m_irq_en) << 9) | (32'(m_pol) << 16);
      1: v = 32'(m_psc);
      2: v = 32'(m_per_stg);
      3: v = 32'(m_flag);
      default: if (idx - 4 < int'(CH_NUM)) v = 32'(m_duty_stg[idx-4]);
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_ch_en = 0; m_run = 0; m_irq_en = 0; m_pol = 0; m_psc = 0; m_per_stg = 0;
    m_per_act = 0; m_psc_cnt = 0; m_cnt = 0; m_flag = 0; m_irq = 0;
    m_rdata = '0; m_pwm = '0;
    for (int n = 0; n < int'(CH_NUM); n++) begin
      m_duty_stg[n] = 0;
      m_duty_act[n] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_step();
    int idx;
    bit wr_en, rd_en, tick_ev, wrap;
    idx   = int'(addr[4:2]);
    wr_en = sel && we;
    rd_en = sel && !we;
    if (rst) begin
      model_reset();
      return;
    end
    tick_ev = (m_run != 0) && (m_psc_cnt == m_psc);
    wrap    = tick_ev && (m_cnt == m_per_act);
    for (int n = 0; n < int'(CH_NUM); n++) begin
      m_pwm[n] = ((m_run != 0) && m_ch_en[n] && (m_cnt < m_duty_act[n])) ^ m_pol[n];
    end
    m_irq = m_flag & m_irq_en;
    if (rd_en) m_rdata = model_reg(idx);
    if (m_run == 0) begin
      m_psc_cnt = 0;
      m_cnt     = 0;
    end else if (tick_ev) begin
      m_psc_cnt = 0;
      m_cnt     = wrap ? 0 : m_cnt + 1;
    end else begin
      m_psc_cnt = (m_psc_cnt + 1) % PscMod;
    end
    if (wrap || m_run == 0) begin
      m_per_act = m_per_stg;
      for (int n = 0; n < int'(CH_NUM); n++) m_duty_act[n] = m_duty_stg[n];
    end
    if (wrap) m_flag = 1;
    else if (wr_en && idx == 3 && wdata[0]) m_flag = 0;
    if (wr_en) begin
      case (idx)
        0: begin
          m_ch_en  = int'(wdata[3:0]) & ChMask;
          m_run    = int'(wdata[8]);
          m_irq_en = int'(wdata[9]);
          m_pol    = int'(wdata[19:16]) & ChMask;
        end
        1: m_psc     = int'(wdata[PSC_W-1:0]);
        2: m_per_stg = int'(wdata[CNT_W-1:0]);
        3: ;
        default: if (idx - 4 < int'(CH_NUM)) m_duty_stg[idx-4] = int'(wdata[CNT_W-1:0]);
      endcase
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check_eq("pwm_vs_model", 32'(pwm), 32'(m_pwm));
    check_eq("irq_vs_model", 32'(irq), 32'(m_irq));
    check_eq("rdata_vs_model", rdata, m_rdata);
  endtask

  task automatic wr(input int idx, input logic [31:0] data);
    sel = 1'b1; we = 1'b1; addr = 5'(idx << 2); wdata = data;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input int idx, input logic [31:0] exp, input string tag);
    sel = 1'b1; we = 1'b0; addr = 5'(idx << 2);
    tick();
    sel = 1'b0;
    check_eq(tag, rdata, exp);
  endtask

  task automatic wait_rise(input int ch);
    logic prev;
    int   n;
    n = 0;
    do begin
      prev = pwm[ch];
      tick();
      n++;
    end while (!(prev == 1'b0 && pwm[ch] == 1'b1) && n < 200);
    if (n >= 200) check_eq("pwm_rise_timeout", 32'd0, 32'd1);
  endtask

  // Length of the run of equal samples starting at the current sample
  task automatic run_len(input int ch, output int n);
    logic lv;
    lv = pwm[ch];
    n  = 0;
    while (pwm[ch] == lv && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic count_high(input int ch, input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (pwm[ch]) n++;
    end
  endtask

  task automatic wait_irq_rise(output int t);
    logic prev;
    int   n;
    n = 0;
    do begin
      prev = irq;
      tick();
      n++;
    end while (!(prev == 1'b0 && irq == 1'b1) && n < 200);
    if (n >= 200) check_eq("irq_rise_timeout", 32'd0, 32'd1);
    t = cyc;
  endtask

  initial begin
    int n, t1, t2;
    model_reset();

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_eq("reset_pwm", 32'(pwm), 32'd0);
    check_eq("reset_irq", 32'(irq), 32'd0);
    check_eq("reset_rdata", rdata, 32'd0);
    for (int i = 0; i < 8; i++) rd(i, 32'd0, "reset_read");

    // Basic PWM: 3 high / 7 low
    wr(1, 32'd0);
    wr(2, 32'd9);
    wr(4, 32'd3);
    wr(0, 32'h101);
    wait_rise(0);
    run_len(0, n); check_eq("basic_high", 32'(n), 32'd3);
    run_len(0, n); check_eq("basic_low", 32'(n), 32'd7);

    // Shadow: DUTY0=7 written during a high phase takes effect next period
    begin
      int hc;
      hc = 1;
      wr(4, 32'd7);
      run_len(0, n);
      hc = hc + n;
      check_eq("shadow_cur_high", 32'(hc), 32'd3);
    end
    run_len(0, n); check_eq("shadow_cur_low", 32'(n), 32'd7);
    run_len(0, n); check_eq("shadow_next_high", 32'(n), 32'd7);
    run_len(0, n); check_eq("shadow_next_low", 32'(n), 32'd3);
    rd(4, 32'd7, "duty0_readback");

    // Boundaries
    wr(4, 32'd0);
    repeat (25) tick();
    count_high(0, 20, n); check_eq("duty0_const_low", 32'(n), 32'd0);
    wr(4, 32'd10);
    repeat (25) tick();
    count_high(0, 20, n); check_eq("duty_gt_period_high", 32'(n), 32'd20);
    wr(0, 32'h0001_0100);
    repeat (3) tick();
    count_high(0, 20, n); check_eq("disabled_pol_high", 32'(n), 32'd20);

    // Prescaler and irq
    wr(0, 32'h0);
    wr(1, 32'd3);
    wr(2, 32'd4);
    wr(3, 32'd1);
    rd(3, 32'd0, "status_cleared");
    wr(0, 32'h300);
    wait_irq_rise(t1);
    wr(3, 32'd1);
    wait_irq_rise(t2);
    check_eq("irq_interval", 32'(t2 - t1), 32'd20);
    wr(3, 32'd1);
    while (cyc < t2 + 18) tick();
    wr(3, 32'd1);
    tick();
    check_eq("w1c_vs_wrap_irq", 32'(irq), 32'd1);
    rd(3, 32'd1, "w1c_vs_wrap_flag");

    // Stop mid-period, then restart from zero with new staging
    wr(0, 32'h0);
    wr(1, 32'd0);
    wr(2, 32'd9);
    wr(4, 32'd3);
    wr(0, 32'h101);
    repeat (5) tick();
    wr(0, 32'h0001_0001);
    tick();
    check_eq("stop_idle_pol", 32'(pwm[0]), 32'd1);
    wr(4, 32'd2);
    wr(0, 32'h101);
    tick();
    check_eq("restart_first", 32'(pwm[0]), 32'd1);
    run_len(0, n); check_eq("restart_high", 32'(n), 32'd2);
    run_len(0, n); check_eq("restart_low", 32'(n), 32'd8);

    // Random traffic against the model
    for (int it = 0; it < 1500; it++) begin
      int op, idx;
      logic [31:0] d;
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else if (op <= 3) begin
        tick();
      end else if (op <= 5) begin
        idx  = int'($urandom_range(0, 7));
        sel  = 1'b1; we = 1'b0;
        addr = {3'(idx), 2'($urandom_range(0, 3))};
        tick();
        sel  = 1'b0;
      end else begin
        idx = int'($urandom_range(0, 7));
        case (idx)
          0: begin
            d = $urandom;
            d[8] = ($urandom_range(0, 3) != 0);
          end
          1:       d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
          2:       d = 32'($urandom_range(0, 15));
          3:       d = 32'($urandom_range(0, 1));
          default: d = 32'($urandom_range(0, 17));
        endcase
        sel  = 1'b1; we = 1'b1;
        addr = {3'(idx), 2'($urandom_range(0, 3))};
        wdata = d;
        tick();
        sel = 1'b0; we = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
